// File: rtl/cart_mapper_pkg.sv
// Shared types and helpers for the multi-cartridge bank mapper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cart_mapper_pkg;

    typedef enum logic [1:0] {
        KONAMI     = 2'd0,
        KONAMI_SCC = 2'd1,
        ASCII8     = 2'd2,
        ASCII16    = 2'd3
    } mapper_t;

    // Base addresses of the four 8 KB CPU pages served by the mapper
    localparam logic [15:0] PAGE0_BASE = 16'h4000;
    localparam logic [15:0] PAGE1_BASE = 16'h6000;
    localparam logic [15:0] PAGE2_BASE = 16'h8000;
    localparam logic [15:0] PAGE3_BASE = 16'hA000;

    // Bank mask for an image of mem_size bytes: next power of two of the
    // 8 KB bank count, minus one, saturated to the bank register width.
    function automatic logic [31:0] bank_mask(input logic [24:0] mem_size,
                                              input int          bank_bits);
        logic [12:0] nbanks;
        logic [12:0] m;
        logic [31:0] lim;
        logic [31:0] res;
        nbanks = 13'(({1'b0, mem_size} + 26'd8191) >> 13);
        m = '0;
        for (int i = 0; i < 13; i++) begin
            if (({1'b0, m} + 14'd1) < {1'b0, nbanks})
                m = {m[11:0], 1'b1};
        end
        res = 32'(m);
        lim = (32'd1 << bank_bits) - 32'd1;
        if (bank_bits < 13 && res > lim)
            res = lim;
        return res;
    endfunction

endpackage

// File: rtl/cart_mapper_ctx.sv
// One cartridge context: four bank registers, SCC enable, SCC+ mode register (MAPPER_SCCPLUS_EN), type tracking.
// Latency: writes and type-change reinit take effect on the next clk edge.
// Backpressure: none; every qualified write is accepted the cycle it is presented.
module cart_mapper_ctx
    import cart_mapper_pkg::*;
#(
    parameter int BANK_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [15:0]               addr,
    input  logic [7:0]                din,
    input  logic [1:0]                type_in,
`ifdef MAPPER_SCCPLUS_EN
    input  logic                      scc_plus,
    output logic [7:0]                scc_mode_reg,
`endif
    output logic [3:0][BANK_BITS-1:0] banks,
    output logic                      scc_en,
    output logic [1:0]                type_q
);

    logic                 plus_eff;
    logic [BANK_BITS-1:0] dbank;
    logic [BANK_BITS-2:0] half;

`ifdef MAPPER_SCCPLUS_EN
    assign plus_eff = scc_plus;
    logic unused_addr;
    assign unused_addr = addr[0];
`else
    assign plus_eff = 1'b0;
    logic unused_addr;
    assign unused_addr = ^addr[10:0];
`endif

    // Raw data as a bank number, and the ASCII16 16 KB page index
    assign dbank = BANK_BITS'(din);
    assign half  = (BANK_BITS-1)'(din);

    // Register file: reset, then type-change reinit (beats CPU writes), then CPU write decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++)
                banks[k] <= BANK_BITS'(k);
            scc_en <= 1'b0;
            type_q <= 2'd0;
`ifdef MAPPER_SCCPLUS_EN
            scc_mode_reg <= 8'h00;
`endif
        end else if (type_in != type_q) begin
            for (int k = 0; k < 4; k++)
                banks[k] <= type_in[1] ? '0 : BANK_BITS'(k);
            scc_en <= 1'b0;
            type_q <= type_in;
`ifdef MAPPER_SCCPLUS_EN
            scc_mode_reg <= 8'h00;
`endif
        end else if (wr) begin
            unique case (mapper_t'(type_q))
                KONAMI: begin
                    case (addr[15:13])
                        3'b011:  banks[1] <= dbank;
                        3'b100:  banks[2] <= dbank;
                        3'b101:  banks[3] <= dbank;
                        default: ;
                    endcase
                end
                KONAMI_SCC: begin
                    case (addr[15:11])
                        5'b01010: banks[0] <= dbank;
                        5'b01110: banks[1] <= dbank;
                        5'b10010: begin
                            banks[2] <= dbank;
                            if (!plus_eff)
                                scc_en <= (din[5:0] == 6'h3F);
                        end
                        5'b10110: banks[3] <= dbank;
                        default:  ;
                    endcase
`ifdef MAPPER_SCCPLUS_EN
                    // BFFE/BFFF: SCC+ mode register
                    if (scc_plus && addr[15:1] == 15'h5FFF)
                        scc_mode_reg <= din;
`endif
                end
                ASCII8: begin
                    if (addr[15:13] == 3'b011)
                        banks[addr[12:11]] <= dbank;
                end
                ASCII16: begin
                    if (addr[15:11] == 5'b01100) begin
                        banks[0] <= {half, 1'b0};
                        banks[1] <= {half, 1'b1};
                    end else if (addr[15:11] == 5'b01110) begin
                        banks[2] <= {half, 1'b0};
                        banks[3] <= {half, 1'b1};
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/cart_mapper_multi.sv
// Multi-cartridge Konami/Konami-SCC/ASCII8/ASCII16 bank mapper; SCC+ support under MAPPER_SCCPLUS_EN.
// Latency: mem_addr/scc_req/mem_unmaped combinational from state; bank mask registered (1 cycle after mem_size change).
// Backpressure: none; accesses are decoded the cycle they are presented.
module cart_mapper_multi
    import cart_mapper_pkg::*;
#(
    parameter  int NUM_CARTS = 2,
    parameter  int BANK_BITS = 8,
    localparam int CW        = (NUM_CARTS > 1) ? $clog2(NUM_CARTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [24:0]            mem_size,
    input  logic [2*NUM_CARTS-1:0] mapper_type,
    input  logic [15:0]            cpu_addr,
    input  logic [7:0]             din,
    input  logic                   cpu_mreq,
    input  logic                   cpu_wr,
    input  logic                   cpu_rd,
    input  logic                   cs,
    input  logic [CW-1:0]          cart_num,
    input  logic                   scc_plus,
    output logic                   mem_unmaped,
    output logic [BANK_BITS+12:0]  mem_addr,
    output logic                   scc_req,
    output logic [NUM_CARTS-1:0]   scc_mode
);

    logic [3:0][BANK_BITS-1:0] bank_r [NUM_CARTS];
    logic                      en_r   [NUM_CARTS];
    logic [1:0]                type_r [NUM_CARTS];

    logic [3:0][BANK_BITS-1:0] sel_banks;
    logic                      sel_en;
    logic [1:0]                sel_type;
    logic [BANK_BITS-1:0]      mask_q;
    logic                      wr_any;
    logic [2:0]                pg3;
    logic [1:0]                page;
    logic                      mapped;
    logic                      is_scc_type;
    logic                      access;
    logic                      scc_area;
    logic                      write_enable;

    assign wr_any = cs & cpu_mreq & cpu_wr;

`ifdef MAPPER_SCCPLUS_EN
    logic [7:0] mode_r [NUM_CARTS];
    logic [7:0] sel_mode;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CARTS; gi++) begin : g_ctx
            cart_mapper_ctx #(.BANK_BITS(BANK_BITS)) u_ctx (
                .clk          (clk),
                .reset        (reset),
                .wr           (wr_any & (cart_num == CW'(gi))),
                .addr         (cpu_addr),
                .din          (din),
                .type_in      (mapper_type[2*gi +: 2]),
`ifdef MAPPER_SCCPLUS_EN
                .scc_plus     (scc_plus),
                .scc_mode_reg (mode_r[gi]),
`endif
                .banks        (bank_r[gi]),
                .scc_en       (en_r[gi]),
                .type_q       (type_r[gi])
            );
`ifdef MAPPER_SCCPLUS_EN
            // SCC+ sound mode is live when the mode register and bank3 bit 7 both select it
            assign scc_mode[gi] = scc_plus & (mapper_t'(type_r[gi]) == KONAMI_SCC)
                                & mode_r[gi][5] & (|(bank_r[gi][3] & BANK_BITS'(128)));
`endif
        end
    endgenerate

`ifndef MAPPER_SCCPLUS_EN
    assign scc_mode = '0;
    logic unused_scc_plus;
    assign unused_scc_plus = scc_plus;
`endif

    // Bank mask tracks the image size of the addressed cart, one cycle behind
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mask_q <= '1;
        else
            mask_q <= BANK_BITS'(bank_mask(mem_size, BANK_BITS));
    end

    // Select the addressed cart's state
    always_comb begin
        sel_banks = bank_r[0];
        sel_en    = en_r[0];
        sel_type  = type_r[0];
`ifdef MAPPER_SCCPLUS_EN
        sel_mode  = mode_r[0];
`endif
        for (int i = 1; i < NUM_CARTS; i++) begin
            if (cart_num == CW'(i)) begin
                sel_banks = bank_r[i];
                sel_en    = en_r[i];
                sel_type  = type_r[i];
`ifdef MAPPER_SCCPLUS_EN
                sel_mode  = mode_r[i];
`endif
            end
        end
    end

    // Pages 4000..BFFF map to bank0..bank3; everything else is unmapped
    assign pg3      = cpu_addr[15:13] - 3'd2;
    assign mapped   = (pg3 < 3'd4);
    assign page     = pg3[1:0];
    assign mem_addr = {sel_banks[page] & mask_q, cpu_addr[12:0]};

    assign is_scc_type = (mapper_t'(sel_type) == KONAMI_SCC);
    assign access      = cpu_mreq & (cpu_rd | cpu_wr) & is_scc_type;
    assign scc_area    = (cpu_addr[15:11] == 5'b10011);

`ifdef MAPPER_SCCPLUS_EN
    logic plus_hit_a;
    logic plus_hit_b;
    logic ram_bit;
    // SCC+ register windows and per-page RAM enables
    always_comb begin
        plus_hit_a = scc_plus & sel_mode[5] & (|(sel_banks[3] & BANK_BITS'(128)))
                   & (cpu_addr[15:8] == 8'hB8);
        plus_hit_b = scc_plus & ~sel_mode[5]
                   & ((sel_banks[2] & BANK_BITS'(63)) == BANK_BITS'(63)) & scc_area;
        ram_bit    = sel_mode[4];
        case (page)
            2'd0:    ram_bit = sel_mode[4] | sel_mode[0];
            2'd1:    ram_bit = sel_mode[4] | sel_mode[1];
            2'd2:    ram_bit = sel_mode[4] | (sel_mode[5] & sel_mode[2]);
            default: ram_bit = sel_mode[4];
        endcase
    end
    assign write_enable = scc_plus & is_scc_type & mapped & ram_bit;
    assign scc_req      = access & (plus_hit_a | plus_hit_b | (~scc_plus & sel_en & scc_area));
`else
    assign write_enable = 1'b0;
    assign scc_req      = access & sel_en & scc_area;
`endif

    // Writes to read-only space are not served; suppressed while in reset
    assign mem_unmaped = cs & (scc_req | ~mapped | (cpu_mreq & cpu_wr & ~write_enable & ~reset));

endmodule

// File: tb/tb_cart_mapper_multi.sv
module tb_cart_mapper_multi;
    localparam int NC = 2;
    localparam int BB = 8;
`ifdef MAPPER_SCCPLUS_EN
    localparam bit PLUS_BUILT = 1'b1;
`else
    localparam bit PLUS_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] mem_size;
    logic [3:0]  mapper_type;
    logic [15:0] cpu_addr;
    logic [7:0]  din;
    logic        cpu_mreq, cpu_wr, cpu_rd, cs;
    logic [0:0]  cart_num;
    logic        scc_plus;
    logic        mem_unmaped;
    logic [20:0] mem_addr;
    logic        scc_req;
    logic [1:0]  scc_mode;

    cart_mapper_multi #(.NUM_CARTS(NC), .BANK_BITS(BB)) dut (
        .clk(clk), .reset(reset), .mem_size(mem_size), .mapper_type(mapper_type),
        .cpu_addr(cpu_addr), .din(din), .cpu_mreq(cpu_mreq), .cpu_wr(cpu_wr),
        .cpu_rd(cpu_rd), .cs(cs), .cart_num(cart_num), .scc_plus(scc_plus),
        .mem_unmaped(mem_unmaped), .mem_addr(mem_addr), .scc_req(scc_req),
        .scc_mode(scc_mode)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-cart state as plain integers
    int m_bank [NC][4];
    int m_mr   [NC];
    bit m_en   [NC];
    int m_type [NC];
    int m_mask;
    int sizes  [NC];

    function automatic int ref_mask(int sz);
        int nb, p;
        nb = (sz + 8191) / 8192;
        if (nb == 0) return 0;
        p = 1;
        while (p < nb) p = p * 2;
        return (p - 1 > 255) ? 255 : p - 1;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < 4; k++) m_bank[c][k] = k;
            m_mr[c] = 0; m_en[c] = 0; m_type[c] = 0;
        end
        m_mask = 255;
    endfunction

    function automatic bit in_rng(int a, int lo, int hi);
        return a >= lo && a < hi;
    endfunction

    function automatic void model_write(int i);
        int a, d, t, n;
        bit plus;
        a = cpu_addr; d = din; t = m_type[i]; plus = PLUS_BUILT && scc_plus;
        case (t)
            0: begin
                if (in_rng(a, 'h6000, 'h8000)) m_bank[i][1] = d;
                if (in_rng(a, 'h8000, 'hA000)) m_bank[i][2] = d;
                if (in_rng(a, 'hA000, 'hC000)) m_bank[i][3] = d;
            end
            1: begin
                if (in_rng(a, 'h5000, 'h5800)) m_bank[i][0] = d;
                if (in_rng(a, 'h7000, 'h7800)) m_bank[i][1] = d;
                if (in_rng(a, 'h9000, 'h9800)) begin
                    m_bank[i][2] = d;
                    if (!plus) m_en[i] = (d % 64) == 63;
                end
                if (in_rng(a, 'hB000, 'hB800)) m_bank[i][3] = d;
                if (plus && (a == 'hBFFE || a == 'hBFFF)) m_mr[i] = d;
            end
            2: if (in_rng(a, 'h6000, 'h8000)) m_bank[i][(a - 'h6000) / 'h800] = d;
            default: begin
                n = d % 128;
                if (in_rng(a, 'h6000, 'h6800)) begin m_bank[i][0] = 2*n; m_bank[i][1] = 2*n + 1; end
                if (in_rng(a, 'h7000, 'h7800)) begin m_bank[i][2] = 2*n; m_bank[i][3] = 2*n + 1; end
            end
        endcase
    endfunction

    function automatic void model_edge();
        int nt;
        for (int i = 0; i < NC; i++) begin
            nt = mapper_type[2*i +: 2];
            if (nt != m_type[i]) begin
                m_type[i] = nt;
                for (int k = 0; k < 4; k++) m_bank[i][k] = (nt >= 2) ? 0 : k;
                m_mr[i] = 0; m_en[i] = 0;
            end else if (cs && cpu_mreq && cpu_wr && cart_num == i) begin
                model_write(i);
            end
        end
        m_mask = ref_mask(mem_size);
    endfunction

    // Compare all outputs against the model on the falling edge
    task automatic settle(input string tag);
        int a, c, t, pg, mr, ev;
        bit plus, mapped, req, we, in_scc;
        @(negedge clk);
        a = cpu_addr; c = cart_num; t = m_type[c]; mr = m_mr[c];
        plus   = PLUS_BUILT && scc_plus;
        mapped = in_rng(a, 'h4000, 'hC000);
        pg     = mapped ? (a - 'h4000) / 'h2000 : 0;
        in_scc = in_rng(a, 'h9800, 'hA000);
        req = 0;
        if (cpu_mreq && (cpu_rd || cpu_wr) && t == 1) begin
            if (plus)
                req = ((mr & 32) != 0 && m_bank[c][3] >= 128 && a / 256 == 'hB8) ||
                      ((mr & 32) == 0 && m_bank[c][2] % 64 == 63 && in_scc);
            else
                req = m_en[c] && in_scc;
        end
        we = plus && t == 1 && mapped &&
             ((mr & 16) != 0 || (pg == 0 && (mr & 1) != 0) || (pg == 1 && (mr & 2) != 0) ||
              (pg == 2 && (mr & 4) != 0 && (mr & 32) != 0));
        ev = 0;
        for (int i = 0; i < NC; i++)
            if (plus && m_type[i] == 1 && (m_mr[i] & 32) != 0 && m_bank[i][3] >= 128) ev |= (1 << i);
        check_eq({tag, ".unmaped"}, mem_unmaped,
                 cs && (req || !mapped || (cpu_mreq && cpu_wr && !we && !reset)));
        check_eq({tag, ".scc_req"}, scc_req, req);
        check_eq({tag, ".scc_mode"}, scc_mode, ev);
        if (mapped)
            check_eq({tag, ".addr"}, mem_addr, (m_bank[c][pg] & m_mask) * 8192 + a % 8192);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (!reset) model_edge();
    endtask

    task automatic bus(input bit cs_i, input bit mreq_i, input bit wr_i, input bit rd_i,
                       input logic [15:0] a, input logic [7:0] d);
        cs = cs_i; cpu_mreq = mreq_i; cpu_wr = wr_i; cpu_rd = rd_i; cpu_addr = a; din = d;
    endtask

    task automatic idle(input string tag);
        bus(0, 0, 0, 0, 16'h0000, 8'h00);
        settle(tag);
        advance();
    endtask

    task automatic wr_op(input string tag, input logic [15:0] a, input logic [7:0] d);
        bus(1, 1, 1, 0, a, d);
        settle(tag);
        advance();
    endtask

    task automatic rd_begin(input string tag, input logic [15:0] a);
        bus(1, 1, 0, 1, a, 8'h00);
        settle(tag);
    endtask

    logic [15:0] addr_pool [16] = '{16'h4000, 16'h5000, 16'h6000, 16'h6800, 16'h7000, 16'h7800,
                                    16'h8000, 16'h9000, 16'h9800, 16'hA000, 16'hB000, 16'hB800,
                                    16'hBFFE, 16'hBFFF, 16'hC000, 16'h0100};
    logic [7:0]  din_pool  [6]  = '{8'h3F, 8'h20, 8'h80, 8'h30, 8'h13, 8'hFF};
    int          size_pool [6]  = '{0, 8192, 24576, 65536, 1048576, 33554431};

    initial begin
        reset = 1'b1; mem_size = 25'd1048576; mapper_type = 4'b0000; cart_num = 1'b0;
        scc_plus = 1'b0;
        bus(0, 0, 0, 0, 16'h0000, 8'h00);
        model_reset();

        // Reset state
        rd_begin("rst", 16'h6000);
        check_eq("rst_addr", mem_addr, 21'h02000);
        check_eq("rst_scc_req", scc_req, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Type 1 basics
        mapper_type = 4'b0001;
        idle("ty1");
        rd_begin("ty1_rd6000", 16'h6000);
        check_eq("ty1_addr6000", mem_addr, 21'h02000);
        check_eq("ty1_req6000", scc_req, 0);
        advance();
        wr_op("scc_on", 16'h9000, 8'h3F);
        rd_begin("scc_rd", 16'h9800);
        check_eq("scc_req_on", scc_req, 1);
        check_eq("scc_unmaped", mem_unmaped, 1);
        advance();
        wr_op("scc_off", 16'h9000, 8'h00);
        rd_begin("scc_rd2", 16'h9800);
        check_eq("scc_req_off", scc_req, 0);
        advance();

        // SCC+ mode
        scc_plus = 1'b1;
        wr_op("sccp_mode", 16'hBFFE, 8'h20);
        wr_op("sccp_b3", 16'hB000, 8'h80);
        rd_begin("sccp_rd", 16'hB800);
        check_eq("sccp_req", scc_req, PLUS_BUILT);
        check_eq("sccp_mode", scc_mode[0], PLUS_BUILT);
        advance();
        scc_plus = 1'b0;

        // ASCII16 with and without a small mask
        mapper_type = 4'b0011;
        idle("a16");
        wr_op("a16_wr", 16'h7000, 8'h05);
        rd_begin("a16_rd", 16'hA000);
        check_eq("a16_addr", mem_addr, 21'h16000);
        advance();
        mem_size = 25'd65536;
        idle("a16_m1");
        idle("a16_m2");
        rd_begin("a16_rd64k", 16'hA000);
        check_eq("a16_addr64k", mem_addr, 21'h06000);
        advance();
        mem_size = 25'd1048576;
        idle("a16_m3");
        idle("a16_m4");

        // Two carts: ASCII8 write to cart 1 leaves cart 0 alone
        mapper_type = 4'b1011;
        idle("two");
        cart_num = 1'b1;
        wr_op("two_wr", 16'h6800, 8'h07);
        rd_begin("two_rd1", 16'h6000);
        check_eq("two_c1_bank1", mem_addr, 21'h0E000);
        advance();
        cart_num = 1'b0;
        rd_begin("two_rd0", 16'hA000);
        check_eq("two_c0_bank3", mem_addr, 21'h16000);
        advance();
        mapper_type = 4'b0011;
        idle("two_ty0");
        cart_num = 1'b1;
        rd_begin("two_rd1b", 16'h6000);
        check_eq("two_c1_reinit1", mem_addr, 21'h02000);
        advance();
        rd_begin("two_rd1c", 16'hA000);
        check_eq("two_c1_reinit3", mem_addr, 21'h06000);
        advance();

        // Async reset mid-write
        cart_num = 1'b0;
        mapper_type = 4'b0000;
        idle("rw0");
        bus(1, 1, 1, 0, 16'h6000, 8'h09);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_eq("rw_addr", mem_addr, 21'h02000);
        check_eq("rw_unmaped", mem_unmaped, 0);
        check_eq("rw_scc_mode", scc_mode, 0);
        settle("rw_in_rst");
        @(posedge clk); #1 reset = 1'b0;
        rd_begin("rw_after", 16'h6000);
        check_eq("rw_lost", mem_addr, 21'h02000);
        advance();

        // Randomized traffic against the model
        for (int c = 0; c < NC; c++) sizes[c] = size_pool[$urandom_range(0, 5)];
        for (int it = 0; it < 3000; it++) begin
            int r;
            if ($urandom_range(0, 63) == 0) mapper_type = 4'($urandom);
            if ($urandom_range(0, 199) == 0) scc_plus = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) cart_num = 1'($urandom_range(0, 1));
            mem_size = 25'(sizes[cart_num]);
            r = $urandom_range(0, 2);
            cs       = ($urandom_range(0, 7) != 0);
            cpu_mreq = ($urandom_range(0, 7) != 0);
            cpu_wr   = (r == 0);
            cpu_rd   = (r == 1);
            cpu_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                   : addr_pool[$urandom_range(0, 15)] + 16'($urandom_range(0, 1));
            din      = ($urandom_range(0, 1) == 0) ? 8'($urandom) : din_pool[$urandom_range(0, 5)];
            if (it == 1500) begin
                reset = 1'b1;
                model_reset();
                settle("rnd_rst");
                @(posedge clk); #1 reset = 1'b0;
            end else begin
                settle("rnd");
                advance();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
